// File: rtl/ring_window_counter_pkg.sv
// Shared types and constants for the ring-oscillator window counter.
// Imported by ring_window_counter and ring_sync.
package ring_window_counter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCount,
    StDone
  } state_e;

  // Cycles spent flushing the ring synchroniser before counting starts.
  localparam int unsigned SETTLE_CYCLES = 2;

  localparam int unsigned SettleCntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

endpackage

// File: rtl/ring_sync.sv
// Two-flop synchroniser for the free-running ring/chain output.
// Synchronous active-high reset clears both stages to 0.
module ring_sync
  import ring_window_counter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ring_window_counter.sv
// Counts rising edges of an asynchronous ring oscillator over a window of wb_clk_i cycles.
// Optional sticky saturation flag: define RING_WINDOW_COUNTER_OVF_EN.
module ring_window_counter
  import ring_window_counter_pkg::*;
#(
  parameter int unsigned WINDOW_W = 16,
  parameter int unsigned COUNT_W  = 12
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                active,
  input  logic                ring_in,
  input  logic                start,
  input  logic [WINDOW_W-1:0] window_len,
  output logic                enable_ring,
  output logic                busy,
  output logic                done,
  output logic [COUNT_W-1:0]  count,
  output logic                overflow
);

  localparam logic [COUNT_W-1:0]    CountMax   = '1;
  localparam logic [SettleCntW-1:0] SettleLast = SettleCntW'(SETTLE_CYCLES - 1);

  state_e                state_q, state_d;
  logic                  start_q;
  logic [WINDOW_W-1:0]   win_q, win_d;
  logic [WINDOW_W-1:0]   cyc_q, cyc_d;
  logic [SettleCntW-1:0] settle_q, settle_d;
  logic [COUNT_W-1:0]    count_q, count_d;
  logic                  ring_prev_q, ring_prev_d;

  logic ring_s;
  logic start_edge;
  logic accept_start;
  logic ring_rise;
  logic inc_req;

  ring_sync u_ring_sync (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .d_i   (ring_in),
    .q_o   (ring_s)
  );

  assign start_edge   = start & ~start_q;
  assign accept_start = active & start_edge & ((state_q == StIdle) | (state_q == StDone));
  assign ring_rise    = ring_s & ~ring_prev_q;
  assign inc_req      = active & (state_q == StCount) & ring_rise;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    cyc_d       = cyc_q;
    settle_d    = settle_q;
    count_d     = count_q;
    ring_prev_d = ring_prev_q;

    if (!active) begin
      // Deselected: abandon any run, keep the last count visible.
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (accept_start) begin
            count_d  = '0;
            win_d    = window_len;
            cyc_d    = '0;
            settle_d = '0;
            state_d  = (window_len == '0) ? StDone : StSettle;
          end
        end
        StSettle: begin
          settle_d = settle_q + 1'b1;
          if (settle_q == SettleLast) begin
            // Prime the edge detector so the first COUNT cycle sees no false rise.
            ring_prev_d = ring_s;
            state_d     = StCount;
          end
        end
        StCount: begin
          ring_prev_d = ring_s;
          if (ring_rise && (count_q != CountMax)) begin
            count_d = count_q + 1'b1;
          end
          cyc_d = cyc_q + 1'b1;
          if (cyc_q == (win_q - WINDOW_W'(1))) begin
            state_d = StDone;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      win_q       <= '0;
      cyc_q       <= '0;
      settle_q    <= '0;
      count_q     <= '0;
      ring_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      win_q       <= win_d;
      cyc_q       <= cyc_d;
      settle_q    <= settle_d;
      count_q     <= count_d;
      ring_prev_q <= ring_prev_d;
    end
  end

`ifdef RING_WINDOW_COUNTER_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (accept_start) begin
      ovf_d = 1'b0;
    end else if (inc_req && (count_q == CountMax)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  assign enable_ring = (state_q == StSettle) | (state_q == StCount);
  assign busy        = (state_q == StSettle) | (state_q == StCount);
  assign done        = (state_q == StDone);
  assign count       = count_q;

endmodule

// File: tb/tb_ring_window_counter.sv
// Randomised and directed bench for ring_window_counter against a sample-history reference model.
module tb_ring_window_counter;

  localparam int CMAX = 4095;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        active;
  logic        ring_in = 1'b0;
  logic        start;
  logic [15:0] window_len;
  logic        enable_ring;
  logic        busy;
  logic        done;
  logic [11:0] count;
  logic        overflow;

  int n_checks = 0;
  int n_fails  = 0;

  int cyc = 0;
  bit hist [0:65535];
  int ring_mode = 0;
  int ring_hp   = 2;

  ring_window_counter #(
    .WINDOW_W (16),
    .COUNT_W  (12)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .active      (active),
    .ring_in     (ring_in),
    .start       (start),
    .window_len  (window_len),
    .enable_ring (enable_ring),
    .busy        (busy),
    .done        (done),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // cyc == k during the cycle that follows posedge k; hist[k] is ring_in sampled at that edge.
  always @(posedge wb_clk_i) begin
    cyc = cyc + 1;
    hist[cyc] = ring_in;
  end

  always @(negedge wb_clk_i) begin
    case (ring_mode)
      1:       ring_in = ((cyc / ring_hp) % 2) != 0;
      2:       if ($urandom_range(0, 2) == 0) ring_in = ~ring_in;
      default: ring_in = 1'b0;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Rising transitions between consecutive synchronised samples j-1 -> j, j in [lo, hi].
  function automatic int rises(input int lo, input int hi);
    int c = 0;
    for (int j = lo; j <= hi; j++) begin
      if (hist[j] && !hist[j-1]) c++;
    end
    return c;
  endfunction

  // The ring is seen through two flops, so the window of W counted cycles starting two
  // cycles after detection covers sample transitions N+2 .. N+1+W.
  task automatic launch(input int w, output int n);
    @(negedge wb_clk_i);
    window_len = 16'(w);
    start      = 1'b1;
    n          = cyc;
    @(negedge wb_clk_i);
    start      = 1'b0;
    window_len = 16'($urandom);
  endtask

  task automatic measure(input string tag, input int w, input int restart_at);
    int n;
    int done_cyc = -1;
    int busy_c   = 0;
    int en_c     = 0;
    int raw;
    int exp_cnt;
    int exp_ovf;
    launch(w, n);
    check_eq({tag, "/clr_count"}, 32'(count), 0);
    check_eq({tag, "/clr_done"}, 32'(done), 32'(w == 0));
    for (int i = 0; i < w + 20; i++) begin
      if (i > 0) @(negedge wb_clk_i);
      if (i == restart_at) start = 1'b1;
      if (i == restart_at + 1) start = 1'b0;
      if (busy) busy_c++;
      if (enable_ring) en_c++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    check_eq({tag, "/done_cycle"}, 32'(done_cyc), 32'(n + ((w == 0) ? 1 : 3 + w)));
    check_eq({tag, "/busy_cycles"}, 32'(busy_c), 32'((w == 0) ? 0 : w + 2));
    check_eq({tag, "/en_cycles"}, 32'(en_c), 32'((w == 0) ? 0 : w + 2));
    raw     = (w == 0) ? 0 : rises(n + 2, n + 1 + w);
    exp_cnt = (raw > CMAX) ? CMAX : raw;
`ifdef RING_WINDOW_COUNTER_OVF_EN
    exp_ovf = (raw > CMAX) ? 1 : 0;
`else
    exp_ovf = 0;
`endif
    check_eq({tag, "/count"}, 32'(count), 32'(exp_cnt));
    check_eq({tag, "/overflow"}, 32'(overflow), 32'(exp_ovf));
    repeat (3) @(negedge wb_clk_i);
    check_eq({tag, "/done_hold"}, 32'(done), 1);
    check_eq({tag, "/count_hold"}, 32'(count), 32'(exp_cnt));
  endtask

  initial begin
    int n;
    int k;
    int exp_hold;
    wb_rst_i   = 1'b1;
    active     = 1'b1;
    start      = 1'b0;
    window_len = '0;
    repeat (3) @(negedge wb_clk_i);
    check_eq("rst/busy", 32'(busy), 0);
    check_eq("rst/enable_ring", 32'(enable_ring), 0);
    check_eq("rst/done", 32'(done), 0);
    check_eq("rst/count", 32'(count), 0);
    check_eq("rst/overflow", 32'(overflow), 0);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    ring_mode = 1; ring_hp = 2;
    measure("p4_w100", 100, -1);
    check_eq("p4_w100/approx25", 32'((count >= 24) && (count <= 26)), 1);

    ring_mode = 0;
    measure("w0", 0, -1);

    ring_mode = 1; ring_hp = 1;
    measure("p2_w10000", 10000, -1);

    ring_mode = 1; ring_hp = 3;
    measure("restart_mid", 150, 40);
    measure("after_done", 150, -1);

    // Reset in the middle of COUNT.
    ring_mode = 1; ring_hp = 2;
    launch(200, n);
    repeat (60) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    check_eq("rst_mid/busy", 32'(busy), 0);
    check_eq("rst_mid/enable_ring", 32'(enable_ring), 0);
    check_eq("rst_mid/done", 32'(done), 0);
    check_eq("rst_mid/count", 32'(count), 0);
    check_eq("rst_mid/overflow", 32'(overflow), 0);
    repeat (2) @(negedge wb_clk_i);

    // Deselect in the middle of COUNT: count freezes at its last value.
    launch(200, n);
    repeat (60) @(negedge wb_clk_i);
    active   = 1'b0;
    k        = cyc;
    exp_hold = rises(n + 2, k - 2);
    @(negedge wb_clk_i);
    check_eq("inactive/busy", 32'(busy), 0);
    check_eq("inactive/enable_ring", 32'(enable_ring), 0);
    check_eq("inactive/done", 32'(done), 0);
    check_eq("inactive/count", 32'(count), 32'(exp_hold));
    repeat (5) @(negedge wb_clk_i);
    check_eq("inactive/count_hold", 32'(count), 32'(exp_hold));
    active = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    check_eq("reactive/busy", 32'(busy), 0);
    check_eq("reactive/done", 32'(done), 0);

    ring_mode = 2;
    measure("rand_w1", 1, -1);
    for (int r = 0; r < 6; r++) begin
      measure($sformatf("rand%0d", r), int'($urandom_range(1, 300)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ring_window_counter.md
RING_WINDOW_COUNTER -- requirements
Module: ring_window_counter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WINDOW_W, 16, width of window_len (count window in wb_clk_i cycles)
- COUNT_W, 12, width of count result
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- wb_clk_i, in, 1, the single clock
- wb_rst_i, in, 1, synchronous active-high reset
- active, in, 1, project select; low forces idle
- ring_in, in, 1, asynchronous ring/chain output of the instrumented adder
- start, in, 1, level from logic analyser; rising edge launches a measurement
- window_len, in, WINDOW_W, window length, latched on start
- enable_ring, out, 1, enables the adder ring oscillator
- busy, out, 1, measurement in progress
- done, out, 1, result valid
- count, out, COUNT_W, rising edges of ring_in counted in the window
- overflow, out, 1, sticky saturation flag (RING_WINDOW_COUNTER_OVF_EN only)
REQ-003 The design SHALL use one clock, wb_clk_i; reset wb_rst_i SHALL be synchronous and active-high.

Function
REQ-004 The state machine SHALL have the states IDLE, SETTLE, COUNT and DONE.
REQ-005 A start rising edge SHALL be detected from a registered copy of start; the detection cycle is cycle N.
REQ-006 A start edge in IDLE or DONE SHALL clear count, clear done, latch window_len as W, and enter SETTLE at N+1.
REQ-007 If W==0, the FSM SHALL go from IDLE/DONE directly to DONE at N+1 with count=0, and enable_ring SHALL never assert.
REQ-008 SETTLE SHALL last exactly 2 cycles, which flushes the ring synchroniser.
REQ-009 At the last SETTLE cycle, the edge-detect register SHALL be loaded with the synchronised ring value, so no spurious edge is counted.
REQ-010 COUNT SHALL last exactly W cycles (N+3 .. N+2+W); DONE SHALL be entered at N+3+W.
REQ-011 enable_ring SHALL be high exactly in SETTLE and COUNT.
REQ-012 busy SHALL be high exactly in SETTLE and COUNT.
REQ-013 done SHALL be high in DONE and SHALL hold until the next start edge, reset, or active low.
REQ-014 In COUNT, each 0->1 transition of the synchronised ring_in SHALL increment count by 1.
REQ-015 count SHALL saturate at 2^COUNT_W-1 and SHALL never wrap.
REQ-016 Start edges during SETTLE or COUNT SHALL be ignored, and window_len changes after the latch SHALL be ignored.
REQ-017 active=0 SHALL force IDLE on the next cycle with enable_ring, busy and done low; count SHALL hold its value.
REQ-018 A correct count SHALL be guaranteed only when the ring_in frequency is below wb_clk_i/2; faster rings undercount and this is not an error.

Reset
REQ-019 Reset SHALL put the FSM in IDLE and drive enable_ring=0, busy=0, done=0, count=0 and overflow=0.
REQ-020 Reset SHALL clear the start-edge and synchroniser registers to 0.
REQ-021 Reset mid-measurement SHALL abort at the next clock with no partial done.

Configuration
REQ-022 With RING_WINDOW_COUNTER_OVF_EN defined, overflow SHALL be set when an increment is attempted at the maximum count, stay set until the next start edge or reset, and be readable in DONE.
REQ-023 Without RING_WINDOW_COUNTER_OVF_EN, overflow SHALL be tied to 0 and no flag register SHALL exist; saturation is unchanged.

Structure
REQ-024 Package ring_window_counter_pkg SHALL hold the state enum and the constant SETTLE_CYCLES=2.
REQ-025 Sub-module ring_sync (two-flop synchroniser, reset to 0) SHALL synchronise ring_in; all other logic SHALL sit in ring_window_counter.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- Ring period 4 clocks, W=100, start pulse -> done at N+103, count=25 (+/-1), busy 100+2 cycles, overflow=0.
- W=0, start -> done at N+1, count=0, enable_ring never high.
- Ring period 2 clocks, W=10000 -> count=4095; overflow=1 with macro, 0 without.
- Second start edge mid-COUNT -> ignored, result equals the single-run value; start after DONE -> done drops, count cleared, new run.
- wb_rst_i pulsed mid-COUNT -> next cycle IDLE, all outputs 0.
- active dropped mid-COUNT -> IDLE, enable_ring=0, done=0, count holds.
